multicycle_controller: RTL and testbench

- Multicycle ARM control unit: main state machine plus ALU/flag decoder.
- Produces the unconditioned control strobes (pcs, regw, memw, flagw) that the conditional-logic stage gates with condex before they reach the datapath.
- Also drives datapath mux selects, irwrite, nextpc and ALU control for the multicycle datapath.
- Sits between the instruction register and the conditional-logic stage; purely control, holds no datapath state.

---
 rtl/ctrl_pkg.sv | 50 +++++
 rtl/multicycle_controller_alu_decoder.sv | 50 +++++
 rtl/multicycle_controller.sv | 174 +++++++++++++++++
 tb/tb_multicycle_controller.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the multicycle ARM control unit.
//   - state_t       : 4-bit main FSM state encoding
//   - OP_*          : instr[27:26] instruction classes
//   - CMD_*         : data-processing cmd field values (instr[24:21])
//   - SRCB_*/RES_*/ALU_* : datapath select and ALU control encodings
//   - is_cmp()      : recognises the compare command
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_t;

  // Instruction class in instr[27:26]; 2'b11 is undefined and runs as a NOP.
  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [1:0] SRCB_RM   = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  function automatic logic is_cmp(input logic [3:0] cmd);
    return (cmd == CMD_CMP);
  endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// alu_decoder: combinational ALU-control, flag-write and PC-write decode.
// Ports:
//   aluop      in  1  high in the EXECUTE states; otherwise the ALU adds
//   funct      in  5  instr[24:20]: [4:1]=cmd, [0]=S
//   rd         in  4  destination register
//   regw_raw   in  1  register write request from the FSM
//   alucontrol out 2  ALU operation
//   flagw      out 2  [1]=NZ write, [0]=CV write
//   pcs        out 1  PC write caused by a register write to r15
module alu_decoder
  import ctrl_pkg::*;
(
  input  logic       aluop,
  input  logic [4:0] funct,
  input  logic [3:0] rd,
  input  logic       regw_raw,
  output logic [1:0] alucontrol,
  output logic [1:0] flagw,
  output logic       pcs
);

  logic [1:0] w_alu;
  logic [1:0] w_flagw;

  // ALU operation and flag-write enables from the data-processing command.
  always_comb begin
    w_alu   = ALU_ADD;
    w_flagw = 2'b00;
    if (aluop) begin
      case (funct[4:1])
        CMD_ADD:          w_alu = ALU_ADD;
        CMD_SUB, CMD_CMP: w_alu = ALU_SUB;
        CMD_AND:          w_alu = ALU_AND;
        CMD_ORR:          w_alu = ALU_ORR;
        default:          w_alu = ALU_ADD;
      endcase
      // Logical ops leave C and V untouched, so only arithmetic updates CV.
      w_flagw[1] = funct[0];
      w_flagw[0] = funct[0] & ((w_alu == ALU_ADD) | (w_alu == ALU_SUB));
    end else begin
      w_alu   = ALU_ADD;
      w_flagw = 2'b00;
    end
  end

  assign alucontrol = w_alu;
  assign flagw      = w_flagw;
  assign pcs        = (rd == 4'd15) & regw_raw;

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: main FSM of the multicycle ARM control unit.
// Emits unconditioned strobes (pcs, regw, memw, flagw) for the condition
// stage, plus irwrite/nextpc and the datapath mux selects and ALU control.
// Ports:
//   clk, reset           rising-edge clock, synchronous active-high reset
//   op[1:0]              instr[27:26] instruction class
//   funct[5:0]           instr[25:20]: [5]=I, [4:1]=cmd, [0]=S/L
//   rd[3:0]              instr[15:12] destination register
//   pcs, regw, memw      PC / register / memory write requests
//   flagw[1:0]           NZ / CV flag write requests
//   nextpc, irwrite      PC+4 update and IR load (FETCH)
//   adrsrc, alusrca      memory address and ALU A selects
//   alusrcb, resultsrc   ALU B and result selects
//   alucontrol[1:0]      ALU operation
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter bit CMP_NOWRITE = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] op,
  input  logic [5:0] funct,
  input  logic [3:0] rd,
  output logic       pcs,
  output logic       regw,
  output logic       memw,
  output logic [1:0] flagw,
  output logic       nextpc,
  output logic       irwrite,
  output logic       adrsrc,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] resultsrc,
  output logic [1:0] alucontrol
);

  state_t     r_state;
  state_t     w_next_state;
  state_t     w_dec_state;

  logic       w_irwrite;
  logic       w_nextpc;
  logic       w_regw_raw;
  logic       w_memw;
  logic       w_branch;
  logic       w_aluop;
  logic       w_adrsrc;
  logic       w_alusrca;
  logic [1:0] w_alusrcb;
  logic [1:0] w_resultsrc;
  logic [1:0] w_alucontrol;
  logic [1:0] w_flagw;
  logic       w_pcs_dec;

  // State register; reset (and any abort) returns to FETCH.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  // While reset is held the selects show FETCH values regardless of r_state.
  assign w_dec_state = reset ? S_FETCH : r_state;

  // Next-state and Moore output decode.
  always_comb begin
    w_next_state = S_FETCH;
    w_irwrite    = 1'b0;
    w_nextpc     = 1'b0;
    w_regw_raw   = 1'b0;
    w_memw       = 1'b0;
    w_branch     = 1'b0;
    w_aluop      = 1'b0;
    w_adrsrc     = 1'b0;
    w_alusrca    = 1'b0;
    w_alusrcb    = SRCB_RM;
    w_resultsrc  = RES_ALUOUT;
    case (w_dec_state)
      S_FETCH: begin
        w_alusrca    = 1'b1;
        w_alusrcb    = SRCB_FOUR;
        w_resultsrc  = RES_ALU;
        w_irwrite    = 1'b1;
        w_nextpc     = 1'b1;
        w_next_state = S_DECODE;
      end
      S_DECODE: begin
        w_alusrca   = 1'b1;
        w_alusrcb   = SRCB_FOUR;
        w_resultsrc = RES_ALU;
        case (op)
          OP_MEM:  w_next_state = S_MEMADR;
          OP_DP:   w_next_state = funct[5] ? S_EXECUTEI : S_EXECUTER;
          OP_BR:   w_next_state = S_BRANCH;
          default: w_next_state = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        w_alusrcb    = SRCB_IMM;
        w_next_state = funct[0] ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        w_adrsrc     = 1'b1;
        w_next_state = S_MEMWB;
      end
      S_MEMWB: begin
        w_resultsrc  = RES_DATA;
        w_regw_raw   = 1'b1;
        w_next_state = S_FETCH;
      end
      S_MEMWRITE: begin
        w_adrsrc     = 1'b1;
        w_memw       = 1'b1;
        w_next_state = S_FETCH;
      end
      S_EXECUTER: begin
        w_alusrcb    = SRCB_RM;
        w_aluop      = 1'b1;
        w_next_state = S_ALUWB;
      end
      S_EXECUTEI: begin
        w_alusrcb    = SRCB_IMM;
        w_aluop      = 1'b1;
        w_next_state = S_ALUWB;
      end
      S_ALUWB: begin
        w_resultsrc = RES_ALUOUT;
        // A compare only sets flags; optionally keep it off the register file.
        if (CMP_NOWRITE && is_cmp(funct[4:1])) begin
          w_regw_raw = 1'b0;
        end else begin
          w_regw_raw = 1'b1;
        end
        w_next_state = S_FETCH;
      end
      S_BRANCH: begin
        w_alusrcb    = SRCB_IMM;
        w_resultsrc  = RES_ALU;
        w_branch     = 1'b1;
        w_next_state = S_FETCH;
      end
      default: begin
        w_next_state = S_FETCH;
      end
    endcase
  end

  alu_decoder u_alu_decoder (
    .aluop      (w_aluop),
    .funct      (funct[4:0]),
    .rd         (rd),
    .regw_raw   (w_regw_raw),
    .alucontrol (w_alucontrol),
    .flagw      (w_flagw),
    .pcs        (w_pcs_dec)
  );

  // Strobes are suppressed in the reset cycle; selects pass through.
  assign pcs        = (w_pcs_dec | w_branch) & ~reset;
  assign regw       = w_regw_raw & ~reset;
  assign memw       = w_memw & ~reset;
  assign flagw      = w_flagw & {2{~reset}};
  assign nextpc     = w_nextpc & ~reset;
  assign irwrite    = w_irwrite & ~reset;
  assign adrsrc     = w_adrsrc;
  assign alusrca    = w_alusrca;
  assign alusrcb    = w_alusrcb;
  assign resultsrc  = w_resultsrc;
  assign alucontrol = w_alucontrol;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench: each instruction pushes its expected per-cycle control
// vectors (from a behavioural model of the instruction rules); a monitor on
// the falling edge pops and compares one vector per cycle.
module tb_multicycle_controller;

  typedef struct packed {
    logic       pcs;
    logic       regw;
    logic       memw;
    logic [1:0] flagw;
    logic       nextpc;
    logic       irwrite;
    logic       adrsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] resultsrc;
    logic [1:0] alucontrol;
  } ctl_t;

  typedef struct packed {
    int   n;
    int   k;
    ctl_t v;
  } exp_t;

  logic       clk;
  logic       reset;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic       pcs, regw, memw, nextpc, irwrite, adrsrc, alusrca;
  logic [1:0] flagw, alusrcb, resultsrc, alucontrol;

  exp_t exp_q[$];
  int   checks;
  int   errors;
  int   instr_n;

  multicycle_controller #(.CMP_NOWRITE(1'b1)) dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct      (funct),
    .rd         (rd),
    .pcs        (pcs),
    .regw       (regw),
    .memw       (memw),
    .flagw      (flagw),
    .nextpc     (nextpc),
    .irwrite    (irwrite),
    .adrsrc     (adrsrc),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .resultsrc  (resultsrc),
    .alucontrol (alucontrol)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycles an instruction takes, by class.
  function automatic int latency(input logic [1:0] o, input logic [5:0] f);
    case (o)
      2'b00:   return 4;
      2'b01:   return f[0] ? 5 : 4;
      2'b10:   return 3;
      default: return 2;
    endcase
  endfunction

  // Selects shown while reset is asserted: FETCH selects, no strobes.
  function automatic ctl_t reset_vec();
    ctl_t v;
    v = '0;
    v.alusrca   = 1'b1;
    v.alusrcb   = 2'b10;
    v.resultsrc = 2'b10;
    return v;
  endfunction

  // Expected controls in cycle k of an instruction.
  function automatic ctl_t model(input logic [1:0] o, input logic [5:0] f,
                                 input logic [3:0] r, input int k);
    ctl_t       v;
    logic [3:0] cmd;
    logic [1:0] alu;
    logic       s;
    logic       wr;
    v   = '0;
    cmd = f[4:1];
    s   = f[0];
    if (cmd == 4'b0010 || cmd == 4'b1010) alu = 2'b01;
    else if (cmd == 4'b0000) alu = 2'b10;
    else if (cmd == 4'b1100) alu = 2'b11;
    else alu = 2'b00;
    if (k == 0) begin
      v = reset_vec();
      v.irwrite = 1'b1;
      v.nextpc  = 1'b1;
    end else if (k == 1) begin
      v = reset_vec();
    end else if (o == 2'b01) begin
      if (k == 2) v.alusrcb = 2'b01;
      if (k == 3) begin
        v.adrsrc = 1'b1;
        v.memw   = ~f[0];
      end
      if (k == 4) begin
        v.resultsrc = 2'b01;
        v.regw      = 1'b1;
        v.pcs       = (r == 4'd15);
      end
    end else if (o == 2'b00) begin
      if (k == 2) begin
        v.alusrcb    = f[5] ? 2'b01 : 2'b00;
        v.alucontrol = alu;
        v.flagw      = {s, s & (alu == 2'b00 || alu == 2'b01)};
      end
      if (k == 3) begin
        wr     = (cmd != 4'b1010);
        v.regw = wr;
        v.pcs  = wr && (r == 4'd15);
      end
    end else if (o == 2'b10) begin
      v.alusrcb   = 2'b01;
      v.resultsrc = 2'b10;
      v.pcs       = 1'b1;
    end
    return v;
  endfunction

  // Run an instruction; if cut < latency, assert reset in cycle 'cut'.
  task automatic run_instr(input logic [1:0] o, input logic [5:0] f,
                           input logic [3:0] r, input int cut);
    int   lat;
    int   n_run;
    exp_t e;
    lat = latency(o, f);
    n_run = (cut < lat) ? cut : lat;
    op = o;
    funct = f;
    rd = r;
    instr_n++;
    for (int k = 0; k < n_run; k++) begin
      e.n = instr_n;
      e.k = k;
      e.v = model(o, f, r, k);
      exp_q.push_back(e);
    end
    repeat (n_run) @(posedge clk);
    #1;
    if (cut < lat) begin
      reset = 1'b1;
      e.n = instr_n;
      e.k = -1;
      e.v = reset_vec();
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      reset = 1'b0;
    end
  endtask

  // Monitor: one comparison per cycle while expectations are pending.
  always @(negedge clk) begin
    exp_t e;
    ctl_t act;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      act = {pcs, regw, memw, flagw, nextpc, irwrite, adrsrc, alusrca,
             alusrcb, resultsrc, alucontrol};
      checks++;
      if (act !== e.v) begin
        errors++;
        $display("FAIL ctl instr=%0d cyc=%0d actual=%b required=%b (pcs,regw,memw,flagw,nextpc,irwrite,adrsrc,alusrca,alusrcb,resultsrc,alucontrol)",
                 e.n, e.k, act, e.v);
      end
    end
  end

  initial begin
    logic [1:0] ro;
    logic [5:0] rf;
    logic [3:0] rr;
    logic [3:0] cmds [5];
    exp_t       e;
    int         budget;
    checks  = 0;
    errors  = 0;
    instr_n = 0;
    reset   = 1'b1;
    op      = 2'b00;
    funct   = 6'b000000;
    rd      = 4'd0;
    cmds[0] = 4'b0100;
    cmds[1] = 4'b0010;
    cmds[2] = 4'b1010;
    cmds[3] = 4'b0000;
    cmds[4] = 4'b1100;

    // Reset held two cycles with strobes low.
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      e.n = 0;
      e.k = -1;
      e.v = reset_vec();
      exp_q.push_back(e);
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Directed cases.
    run_instr(2'b01, 6'b011001, 4'd3, 99);   // LDR
    run_instr(2'b00, 6'b001001, 4'd2, 99);   // ADDS reg
    run_instr(2'b00, 6'b100001, 4'd4, 99);   // ANDS imm
    run_instr(2'b00, 6'b010101, 4'd15, 99);  // CMP, no writeback
    run_instr(2'b00, 6'b011000, 4'd15, 99);  // ORR to PC
    run_instr(2'b10, 6'b000000, 4'd0, 99);   // branch
    run_instr(2'b11, 6'b000000, 4'd0, 99);   // undefined
    run_instr(2'b01, 6'b011000, 4'd15, 99);  // STR rd=15
    run_instr(2'b01, 6'b011001, 4'd15, 99);  // LDR to PC
    run_instr(2'b01, 6'b011000, 4'd5, 3);    // STR aborted in MEMWRITE
    run_instr(2'b00, 6'b001000, 4'd1, 99);   // ADD after abort

    // Randomized instruction stream with occasional aborts.
    for (int i = 0; i < 300; i++) begin
      ro = 2'($urandom_range(0, 3));
      rf = 6'($urandom);
      if ($urandom_range(0, 1) == 0) rf[4:1] = cmds[$urandom_range(0, 4)];
      rr = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) rr = 4'd15;
      if ($urandom_range(0, 9) == 0) run_instr(ro, rf, rr, $urandom_range(0, 4));
      else run_instr(ro, rf, rr, 99);
    end

    budget = 0;
    while (exp_q.size() > 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
